// File: rtl/bk_port_arbiter.sv
// Backup-RAM port arbiter: serialises loader/RTC writes and unloader reads onto
// the single bk_* port, with unloader starvation protection and save-size bounds.
module bk_port_arbiter #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned MAX_WAIT   = 8
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [17:0]       save_words,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack,
  input  logic              rtc_req,
  input  logic [ADDR_W-1:0] rtc_addr,
  input  logic [DATA_W-1:0] rtc_data,
  output logic              rtc_ack,
  input  logic              ul_req,
  input  logic [ADDR_W-1:0] ul_addr,
  output logic              ul_ack,
  output logic [DATA_W-1:0] ul_rdata,
  output logic              ul_rvalid,
  output logic [ADDR_W-1:0] bk_addr,
  output logic [DATA_W-1:0] bk_data,
  output logic              bk_wr,
  output logic              bk_rd,
  input  logic [DATA_W-1:0] bk_q,
  output logic              oob,
  output logic              busy
);

  localparam int unsigned SW_W   = 18;
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int unsigned LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RWAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                rd_oob_q, rd_oob_d;

  logic                ld_ack_d, rtc_ack_d, ul_ack_d;
  logic                bk_wr_d, bk_rd_d, oob_d, busy_d, rvalid_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   data_d, rdata_d;

  logic                ul_promote, grant_ld, grant_rtc, grant_ul;
  logic                ld_oob, rtc_oob, ul_oob;

  // Arbitration: ld > rtc > ul, unless the unloader has waited MAX_WAIT decisions
  assign ul_promote = ul_req && (wait_q == WAIT_W'(MAX_WAIT));
  assign grant_ul   = ul_req && (ul_promote || (!ld_req && !rtc_req));
  assign grant_ld   = ld_req && !ul_promote;
  assign grant_rtc  = rtc_req && !ld_req && !ul_promote;

  assign ld_oob  = SW_W'(ld_addr)  >= save_words;
  assign rtc_oob = SW_W'(rtc_addr) >= save_words;
  assign ul_oob  = SW_W'(ul_addr)  >= save_words;

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    lat_d     = lat_q;
    rd_oob_d  = rd_oob_q;
    addr_d    = bk_addr;
    data_d    = bk_data;
    rdata_d   = ul_rdata;
    ld_ack_d  = 1'b0;
    rtc_ack_d = 1'b0;
    ul_ack_d  = 1'b0;
    bk_wr_d   = 1'b0;
    bk_rd_d   = 1'b0;
    oob_d     = 1'b0;
    rvalid_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_ul) begin
          state_d  = ST_ACCESS;
          ul_ack_d = 1'b1;
          addr_d   = ul_addr;
          bk_rd_d  = !ul_oob;
          oob_d    = ul_oob;
          rd_oob_d = ul_oob;
          wait_d   = '0;
        end else begin
          if (grant_ld) begin
            state_d  = ST_ACCESS;
            ld_ack_d = 1'b1;
            addr_d   = ld_addr;
            data_d   = ld_data;
            bk_wr_d  = !ld_oob;
            oob_d    = ld_oob;
          end else if (grant_rtc) begin
            state_d   = ST_ACCESS;
            rtc_ack_d = 1'b1;
            addr_d    = rtc_addr;
            data_d    = rtc_data;
            bk_wr_d   = !rtc_oob;
            oob_d     = rtc_oob;
          end
          if (ul_req && (wait_q != WAIT_W'(MAX_WAIT))) begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end

      ST_ACCESS: begin
        // ul_ack is still high here only when the granted access is a read
        lat_d   = '0;
        state_d = ul_ack ? ST_RWAIT : ST_IDLE;
      end

      ST_RWAIT: begin
        if (lat_q == LAT_W'(RD_LATENCY - 1)) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b1;
          rdata_d  = rd_oob_q ? {DATA_W{1'b1}} : bk_q;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!ul_req) begin
      wait_d = '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      lat_q     <= '0;
      rd_oob_q  <= 1'b0;
      ld_ack    <= 1'b0;
      rtc_ack   <= 1'b0;
      ul_ack    <= 1'b0;
      ul_rvalid <= 1'b0;
      ul_rdata  <= '0;
      bk_addr   <= '0;
      bk_data   <= '0;
      bk_wr     <= 1'b0;
      bk_rd     <= 1'b0;
      oob       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      lat_q     <= lat_d;
      rd_oob_q  <= rd_oob_d;
      ld_ack    <= ld_ack_d;
      rtc_ack   <= rtc_ack_d;
      ul_ack    <= ul_ack_d;
      ul_rvalid <= rvalid_d;
      ul_rdata  <= rdata_d;
      bk_addr   <= addr_d;
      bk_data   <= data_d;
      bk_wr     <= bk_wr_d;
      bk_rd     <= bk_rd_d;
      oob       <= oob_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_bk_port_arbiter.sv
// Directed bench for bk_port_arbiter with a small behavioural backup RAM.
module tb_bk_port_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [17:0] save_words = 18'h0;
  logic        ld_req = 1'b0, rtc_req = 1'b0, ul_req = 1'b0;
  logic [16:0] ld_addr = '0, rtc_addr = '0, ul_addr = '0;
  logic [15:0] ld_data = '0, rtc_data = '0;
  logic        ld_ack, rtc_ack, ul_ack, ul_rvalid;
  logic [15:0] ul_rdata, bk_data, bk_q;
  logic [16:0] bk_addr;
  logic        bk_wr, bk_rd, oob, busy;

  int checks = 0;
  int failures = 0;
  int viol = 0;

  logic [15:0] mem [0:1023];

  bk_port_arbiter #(.ADDR_W(17), .DATA_W(16), .RD_LATENCY(2), .MAX_WAIT(8)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .save_words(save_words),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .rtc_req(rtc_req), .rtc_addr(rtc_addr), .rtc_data(rtc_data), .rtc_ack(rtc_ack),
    .ul_req(ul_req), .ul_addr(ul_addr), .ul_ack(ul_ack),
    .ul_rdata(ul_rdata), .ul_rvalid(ul_rvalid),
    .bk_addr(bk_addr), .bk_data(bk_data), .bk_wr(bk_wr), .bk_rd(bk_rd),
    .bk_q(bk_q), .oob(oob), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (bk_wr) mem[bk_addr[9:0]] <= bk_data;
  end
  assign bk_q = mem[bk_addr[9:0]];

  // Protocol monitor: never two strobes or two acks in one cycle
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (bk_wr && bk_rd) viol++;
      if ((int'(ld_ack) + int'(rtc_ack) + int'(ul_ack)) > 1) viol++;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({ld_ack, rtc_ack, ul_ack, ul_rvalid, bk_wr, bk_rd, oob, busy} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000000",
               {ld_ack, rtc_ack, ul_ack, ul_rvalid, bk_wr, bk_rd, oob, busy});
    end
    checks++;
    if ({bk_addr, bk_data, ul_rdata} !== 49'h0) begin
      failures++;
      $display("FAIL reset_data got addr=%h data=%h rdata=%h exp 0", bk_addr, bk_data, ul_rdata);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    save_words = 18'h1000;
    ld_addr = 17'h0010; ld_data = 16'hBEEF; ld_req = 1'b1;
    tick();
    ld_req = 1'b0;
    checks++;
    if ({ld_ack, rtc_ack, ul_ack, bk_wr, bk_rd, oob, busy} !== 7'b1001001) begin
      failures++;
      $display("FAIL wr_access_ctrl got=%b exp=1001001",
               {ld_ack, rtc_ack, ul_ack, bk_wr, bk_rd, oob, busy});
    end
    checks++;
    if (bk_addr !== 17'h0010 || bk_data !== 16'hBEEF) begin
      failures++;
      $display("FAIL wr_access_bus got addr=%h data=%h exp 00010/beef", bk_addr, bk_data);
    end
    tick();
    checks++;
    if ({ld_ack, bk_wr, busy} !== 3'b000) begin
      failures++;
      $display("FAIL wr_after got=%b exp=000", {ld_ack, bk_wr, busy});
    end
    checks++;
    if (mem[10'h010] !== 16'hBEEF || bk_addr !== 17'h0010) begin
      failures++;
      $display("FAIL wr_mem got mem=%h addr=%h exp beef/00010", mem[10'h010], bk_addr);
    end
    // seed the location read back by later tests
    ld_addr = 17'h0005; ld_data = 16'h1234; ld_req = 1'b1;
    tick();
    ld_req = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    ul_addr = 17'h0005; ul_req = 1'b1;
    tick();
    ul_req = 1'b0;
    checks++;
    if ({ul_ack, bk_rd, bk_wr, oob, busy} !== 5'b11001 || bk_addr !== 17'h0005) begin
      failures++;
      $display("FAIL rd_access got=%b addr=%h exp=11001/00005",
               {ul_ack, bk_rd, bk_wr, oob, busy}, bk_addr);
    end
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if ({ul_ack, bk_rd, bk_wr, ul_rvalid, busy} !== 5'b00001) begin
        failures++;
        $display("FAIL rd_wait%0d got=%b exp=00001", i, {ul_ack, bk_rd, bk_wr, ul_rvalid, busy});
      end
    end
    tick();
    checks++;
    if (ul_rvalid !== 1'b1 || ul_rdata !== 16'h1234 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rd_data got v=%b d=%h busy=%b exp 1/1234/0", ul_rvalid, ul_rdata, busy);
    end
    tick();
    checks++;
    if (ul_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rd_pulse got=%b exp=0", ul_rvalid);
    end
  endtask

  task automatic test_starvation();
    int seq[10];
    int n = 0;
    int exp_code;
    save_words = 18'h1000;
    ld_addr = 17'h20; ld_data = 16'h1111;
    rtc_addr = 17'h21; rtc_data = 16'h2222;
    ul_addr = 17'h22;
    ld_req = 1'b1; rtc_req = 1'b1; ul_req = 1'b1;
    for (int cyc = 0; cyc < 200 && n < 10; cyc++) begin
      tick();
      if (ld_ack) begin seq[n] = 1; n++; end
      else if (rtc_ack) begin seq[n] = 2; n++; end
      else if (ul_ack) begin seq[n] = 3; n++; end
    end
    ld_req = 1'b0; rtc_req = 1'b0; ul_req = 1'b0;
    checks++;
    if (n !== 10) begin
      failures++;
      $display("FAIL starve_timeout got=%0d grants exp=10", n);
    end else begin
      for (int i = 0; i < 10; i++) begin
        exp_code = (i == 8) ? 3 : 1;
        checks++;
        if (seq[i] !== exp_code) begin
          failures++;
          $display("FAIL starve_order%0d got=%0d exp=%0d (1=ld 2=rtc 3=ul)", i, seq[i], exp_code);
        end
      end
    end
    repeat (6) tick();
  endtask

  task automatic test_oob();
    save_words = 18'h0100;
    ld_addr = 17'h0100; ld_data = 16'hAAAA; ld_req = 1'b1;
    tick();
    ld_req = 1'b0;
    checks++;
    if ({ld_ack, oob, bk_wr} !== 3'b110) begin
      failures++;
      $display("FAIL oob_wr got=%b exp=110", {ld_ack, oob, bk_wr});
    end
    tick();
    ld_addr = 17'h00FF; ld_data = 16'h5555; ld_req = 1'b1;
    tick();
    ld_req = 1'b0;
    checks++;
    if ({ld_ack, oob, bk_wr} !== 3'b101) begin
      failures++;
      $display("FAIL oob_edge_in got=%b exp=101", {ld_ack, oob, bk_wr});
    end
    tick();
    ul_addr = 17'h01FF; ul_req = 1'b1;
    tick();
    ul_req = 1'b0;
    checks++;
    if ({ul_ack, oob, bk_rd} !== 3'b110) begin
      failures++;
      $display("FAIL oob_rd got=%b exp=110", {ul_ack, oob, bk_rd});
    end
    repeat (2) tick();
    checks++;
    if (ul_rvalid !== 1'b0 || bk_rd !== 1'b0) begin
      failures++;
      $display("FAIL oob_rd_wait got v=%b rd=%b exp 0/0", ul_rvalid, bk_rd);
    end
    tick();
    checks++;
    if (ul_rvalid !== 1'b1 || ul_rdata !== 16'hFFFF) begin
      failures++;
      $display("FAIL oob_rd_data got v=%b d=%h exp 1/ffff", ul_rvalid, ul_rdata);
    end
    save_words = 18'h0;
    ld_addr = 17'h0000; ld_data = 16'h7777; ld_req = 1'b1;
    tick();
    ld_req = 1'b0;
    checks++;
    if ({ld_ack, oob, bk_wr} !== 3'b110) begin
      failures++;
      $display("FAIL oob_zero got=%b exp=110", {ld_ack, oob, bk_wr});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    save_words = 18'h1000;
    ul_addr = 17'h0005; ul_req = 1'b1;
    tick();
    ul_req = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ld_ack, rtc_ack, ul_ack, ul_rvalid, bk_wr, bk_rd, oob, busy} !== 8'h00 ||
        bk_addr !== 17'h0) begin
      failures++;
      $display("FAIL midrst_outs got=%b addr=%h exp 0",
               {ld_ack, rtc_ack, ul_ack, ul_rvalid, bk_wr, bk_rd, oob, busy}, bk_addr);
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ul_rvalid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL midrst_stale got=%0d rvalid pulses exp=0", seen);
    end
    ul_req = 1'b1;
    tick();
    ul_req = 1'b0;
    repeat (3) tick();
    checks++;
    if (ul_rvalid !== 1'b1 || ul_rdata !== 16'h1234) begin
      failures++;
      $display("FAIL midrst_reread got v=%b d=%h exp 1/1234", ul_rvalid, ul_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    save_words = 18'h1000;
    ld_addr = 17'h30; ld_data = 16'hA5A5; ld_req = 1'b1;
    rtc_addr = 17'h31; rtc_data = 16'h5A5A; rtc_req = 1'b1;
    tick();
    ld_req = 1'b0;
    checks++;
    if ({ld_ack, rtc_ack} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_first got=%b exp=10", {ld_ack, rtc_ack});
    end
    tick();
    checks++;
    if ({ld_ack, rtc_ack, bk_wr} !== 3'b000) begin
      failures++;
      $display("FAIL b2b_gap got=%b exp=000", {ld_ack, rtc_ack, bk_wr});
    end
    tick();
    rtc_req = 1'b0;
    checks++;
    if ({ld_ack, rtc_ack, bk_wr} !== 3'b011 || bk_addr !== 17'h31) begin
      failures++;
      $display("FAIL b2b_second got=%b addr=%h exp=011/00031", {ld_ack, rtc_ack, bk_wr}, bk_addr);
    end
    tick();
    checks++;
    if (mem[10'h030] !== 16'hA5A5 || mem[10'h031] !== 16'h5A5A) begin
      failures++;
      $display("FAIL b2b_mem got %h/%h exp a5a5/5a5a", mem[10'h030], mem[10'h031]);
    end
    checks++;
    if (viol !== 0) begin
      failures++;
      $display("FAIL protocol got=%0d violations exp=0", viol);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    test_reset();
    test_single_write();
    test_single_read();
    test_starvation();
    test_oob();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
